// File: rtl/vga_timing_rx.sv
// vga_timing_rx: receive-side VGA timing checker. Samples sync/blank/colour,
// measures line and frame lengths, locks when they match the configured mode
// and regenerates pixel coordinates plus a qualified pixel strobe.
module vga_timing_rx #(
    parameter int H_TOTAL   = 800,
    parameter int V_TOTAL   = 525,
    parameter int H_VISIBLE = 640,
    parameter int V_VISIBLE = 480,
    parameter int TIMEOUT   = 4095
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        blank_in,
    input  logic [5:0]  color_in,
    output logic [9:0]  x,
    output logic [8:0]  y,
    output logic [5:0]  pixel,
    output logic        pixel_valid,
    output logic        frame_start,
    output logic        locked,
    output logic [10:0] line_len,
    output logic [9:0]  frame_lines,
    output logic [7:0]  err_count
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          hsync1_q, hsync2_q, vsync1_q, vsync2_q, blank1_q;
    logic [5:0]    color1_q;
    logic          hFall, vFall;
    logic [10:0]   hCnt_q, hCnt_d, lineNew, lineLen_q, lineLen_d;
    logic [9:0]    vCnt_q, vCnt_d, vCntInc, frameLines_q, frameLines_d;
    logic [TW-1:0] tmoCnt_q, tmoCnt_d;
    logic          tmoHit, lineBad, frameBad, badNow, bad_q, bad_d;
    logic [7:0]    errCount_q, errCount_d;
    logic          frameStart_q, frameStart_d;
    logic          lockNext;
    logic [9:0]    xCnt_q, xCnt_d;
    logic [8:0]    yCnt_q, yCnt_d;
    logic          lineSeen_q, lineSeen_d;
    logic          pixelValid_q, pixelValid_d;
    logic [5:0]    pixel_q, pixel_d;

    // Register the raw inputs once, then keep a second copy of the syncs for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsync1_q <= 1'b1;
            hsync2_q <= 1'b1;
            vsync1_q <= 1'b1;
            vsync2_q <= 1'b1;
            blank1_q <= 1'b1;
            color1_q <= 6'd0;
        end else begin
            hsync1_q <= hsync_in;
            hsync2_q <= hsync1_q;
            vsync1_q <= vsync_in;
            vsync2_q <= vsync1_q;
            blank1_q <= blank_in;
            color1_q <= color_in;
        end
    end

    assign hFall = hsync2_q & ~hsync1_q;
    assign vFall = vsync2_q & ~vsync1_q;

    // Line/frame measurement and the no-hsync watchdog; all counters saturate.
    always_comb begin
        lineNew      = (hCnt_q == 11'h7FF) ? 11'h7FF : hCnt_q + 11'd1;
        hCnt_d       = hFall ? 11'd0 : lineNew;
        lineLen_d    = hFall ? lineNew : lineLen_q;
        vCntInc      = (hFall && vCnt_q != 10'h3FF) ? vCnt_q + 10'd1 : vCnt_q;
        vCnt_d       = vFall ? 10'd0 : vCntInc;
        frameLines_d = vFall ? vCntInc : frameLines_q;
        tmoHit       = (tmoCnt_q == TW'(TIMEOUT));
        tmoCnt_d     = hFall ? '0 : (tmoHit ? tmoCnt_q : tmoCnt_q + 1'b1);
        lineBad      = hFall && (lineNew != 11'(H_TOTAL));
        frameBad     = vFall && (vCntInc != 10'(V_TOTAL));
    end

    // Lock FSM: search for a frame boundary, measure one clean frame, then track.
    always_comb begin
        state_d      = state_q;
        bad_d        = bad_q;
        badNow       = 1'b0;
        errCount_d   = errCount_q;
        frameStart_d = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                if (vFall) begin
                    state_d = ST_MEASURE;
                    bad_d   = 1'b0;
                end
            end
            ST_MEASURE: begin
                badNow = bad_q | lineBad | tmoHit;
                bad_d  = badNow;
                if (vFall) begin
                    if (!badNow && vCntInc == 10'(V_TOTAL)) begin
                        state_d = ST_LOCKED;
                    end
                    bad_d = 1'b0;
                end
            end
            ST_LOCKED: begin
                if (lineBad || frameBad || tmoHit) begin
                    state_d = ST_SEARCH;
                    if (errCount_q != 8'hFF) begin
                        errCount_d = errCount_q + 8'd1;
                    end
                end else if (vFall) begin
                    frameStart_d = 1'b1;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    // Pixel coordinate regeneration; everything is held at zero unless locked next cycle.
    always_comb begin
        lockNext   = (state_d == ST_LOCKED);
        xCnt_d     = xCnt_q;
        yCnt_d     = yCnt_q;
        lineSeen_d = lineSeen_q;
        if (hFall) begin
            xCnt_d     = 10'd0;
            lineSeen_d = ~blank1_q;
            if (lineSeen_q && yCnt_q != 9'(V_VISIBLE - 1)) begin
                yCnt_d = yCnt_q + 9'd1;
            end
        end else if (!blank1_q) begin
            if (!lineSeen_q) begin
                xCnt_d     = 10'd0;
                lineSeen_d = 1'b1;
            end else if (xCnt_q != 10'(H_VISIBLE - 1)) begin
                xCnt_d = xCnt_q + 10'd1;
            end
        end
        if (vFall) begin
            yCnt_d = 9'd0;
        end
        if (!lockNext) begin
            xCnt_d     = 10'd0;
            yCnt_d     = 9'd0;
            lineSeen_d = 1'b0;
        end
        pixelValid_d = lockNext & ~blank1_q;
        pixel_d      = pixelValid_d ? color1_q : 6'd0;
    end

    // State, measurement and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_SEARCH;
            bad_q        <= 1'b0;
            hCnt_q       <= 11'd0;
            vCnt_q       <= 10'd0;
            lineLen_q    <= 11'd0;
            frameLines_q <= 10'd0;
            tmoCnt_q     <= '0;
            errCount_q   <= 8'd0;
            frameStart_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bad_q        <= bad_d;
            hCnt_q       <= hCnt_d;
            vCnt_q       <= vCnt_d;
            lineLen_q    <= lineLen_d;
            frameLines_q <= frameLines_d;
            tmoCnt_q     <= tmoCnt_d;
            errCount_q   <= errCount_d;
            frameStart_q <= frameStart_d;
        end
    end

    // Pixel-side output registers, aligned with the status registers above.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xCnt_q       <= 10'd0;
            yCnt_q       <= 9'd0;
            lineSeen_q   <= 1'b0;
            pixelValid_q <= 1'b0;
            pixel_q      <= 6'd0;
        end else begin
            xCnt_q       <= xCnt_d;
            yCnt_q       <= yCnt_d;
            lineSeen_q   <= lineSeen_d;
            pixelValid_q <= pixelValid_d;
            pixel_q      <= pixel_d;
        end
    end

    assign x           = xCnt_q;
    assign y           = yCnt_q;
    assign pixel       = pixel_q;
    assign pixel_valid = pixelValid_q;
    assign frame_start = frameStart_q;
    assign locked      = (state_q == ST_LOCKED);
    assign line_len    = lineLen_q;
    assign frame_lines = frameLines_q;
    assign err_count   = errCount_q;

endmodule

// File: tb/tb_vga_timing_rx.sv
// tb_vga_timing_rx: directed bench for vga_timing_rx using a scaled-down
// video mode (40 clocks x 20 lines, 24x12 visible) so every scenario stays short.
module tb_vga_timing_rx;

    localparam int HT  = 40;
    localparam int VT  = 20;
    localparam int HV  = 24;
    localparam int VV  = 12;
    localparam int TMO = 100;
    localparam int HS0 = 28;
    localparam int HSW = 4;
    localparam int VS0 = 14;
    localparam int VSW = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        hsync_in, vsync_in, blank_in;
    logic [5:0]  color_in;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [5:0]  pixel;
    logic        pixel_valid, frame_start, locked;
    logic [10:0] line_len;
    logic [9:0]  frame_lines;
    logic [7:0]  err_count;

    int assertCount = 0;
    int failCount   = 0;

    int hc, vc, curLen, vTot, lastHc, lastVc;
    bit hsHold;

    int validCount, misalign, fsCount, xMax, yMax, xMin, yMin;
    bit everLocked;

    vga_timing_rx #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_VISIBLE(HV), .V_VISIBLE(VV), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in), .color_in(color_in),
        .x(x), .y(y), .pixel(pixel), .pixel_valid(pixel_valid), .frame_start(frame_start),
        .locked(locked), .line_len(line_len), .frame_lines(frame_lines), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        assertCount++;
        if (observed != expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic clearStats();
        validCount = 0; misalign = 0; fsCount = 0;
        xMax = -1; yMax = -1; xMin = 1000; yMin = 1000;
        everLocked = 0;
    endtask

    // One pixel clock: sample outputs on the falling edge, then drive the next generator pixel.
    task automatic applyStimulus();
        @(negedge clk);
        if (pixel_valid) begin
            validCount++;
            if (pixel != x[5:0]) misalign++;
            if (int'(x) > xMax) xMax = int'(x);
            if (int'(x) < xMin) xMin = int'(x);
            if (int'(y) > yMax) yMax = int'(y);
            if (int'(y) < yMin) yMin = int'(y);
        end
        if (frame_start) fsCount++;
        if (locked) everLocked = 1;
        hsync_in = hsHold ? 1'b1 : !(hc >= HS0 && hc < HS0 + HSW);
        vsync_in = !(vc >= VS0 && vc < VS0 + VSW);
        blank_in = !(hc < HV && vc < VV);
        color_in = hc[5:0];
        lastHc = hc;
        lastVc = vc;
        if (hc == curLen - 1) begin
            hc = 0;
            curLen = HT;
            vc = (vc == vTot - 1) ? 0 : vc + 1;
        end else begin
            hc++;
        end
    endtask

    task automatic runSteps(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic runToPos(input int vT, input int hT);
        bit found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            applyStimulus();
            if (lastVc == vT && lastHc == hT) found = 1;
        end
        if (!found) checkOutput("posReached", 0, 1);
    endtask

    task automatic runToHc(input int hT);
        bit found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            applyStimulus();
            if (lastHc == hT) found = 1;
        end
        if (!found) checkOutput("hcReached", 0, 1);
    endtask

    task automatic runToVfall();
        runToPos(VS0, 0);
    endtask

    task automatic applyReset();
        reset    = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        blank_in = 1'b1;
        color_in = 6'd0;
        hsHold   = 0;
        repeat (3) @(negedge clk);
        checkOutput("rstLocked", int'(locked), 0);
        checkOutput("rstLineLen", int'(line_len), 0);
        checkOutput("rstErr", int'(err_count), 0);
        reset  = 1'b1;
        hc     = 0;
        vc     = 0;
        curLen = HT;
    endtask

    initial begin
        bit gotLock;
        reset    = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        blank_in = 1'b1;
        color_in = 6'd0;
        clearStats();

        // Wrong frame height: must never lock and never count an error.
        vTot = VT + 1;
        applyReset();
        runSteps(3 * (VT + 1) * HT);
        checkOutput("tallFrameLines", int'(frame_lines), VT + 1);
        checkOutput("tallLineLen", int'(line_len), HT);
        checkOutput("tallNeverLocked", int'(everLocked), 0);
        checkOutput("tallErr", int'(err_count), 0);

        // Correct timing from reset: lock one clock after the second vsync fall.
        vTot = VT;
        applyReset();
        runToVfall();
        runSteps(2);
        checkOutput("firstVfallNoLock", int'(locked), 0);
        runToVfall();
        runSteps(1);
        checkOutput("lockNotEarly", int'(locked), 0);
        runSteps(1);
        checkOutput("lockRise", int'(locked), 1);
        checkOutput("lockLineLen", int'(line_len), HT);
        checkOutput("lockFrameLines", int'(frame_lines), VT);

        // Full locked frame: pixel count, coordinate span, colour alignment, one frame_start.
        clearStats();
        runToVfall();
        runSteps(2);
        checkOutput("frameValidCount", validCount, HV * VV);
        checkOutput("frameMisalign", misalign, 0);
        checkOutput("frameStartCount", fsCount, 1);
        checkOutput("frameXMin", xMin, 0);
        checkOutput("frameXMax", xMax, HV - 1);
        checkOutput("frameYMin", yMin, 0);
        checkOutput("frameYMax", yMax, VV - 1);
        clearStats();
        runToVfall();
        runSteps(2);
        checkOutput("frame2StartCount", fsCount, 1);
        checkOutput("frame2ValidCount", validCount, HV * VV);

        // One stretched line drops lock; relock after a clean frame.
        runToPos(3, 0);
        curLen = HT + 1;
        runToPos(4, HS0);
        runSteps(1);
        checkOutput("stretchStillLocked", int'(locked), 1);
        runSteps(1);
        checkOutput("stretchDrop", int'(locked), 0);
        checkOutput("stretchErr", int'(err_count), 1);
        checkOutput("stretchLineLen", int'(line_len), HT + 1);
        runToVfall();
        runSteps(2);
        checkOutput("stretchSearch", int'(locked), 0);
        runToVfall();
        runSteps(2);
        checkOutput("stretchRelock", int'(locked), 1);
        checkOutput("stretchErrHeld", int'(err_count), 1);

        // Stuck hsync: lock lost at the watchdog limit, saturated line length afterwards.
        runToPos(5, HS0);
        hsHold = 1;
        runSteps(95);
        checkOutput("tmoNotYet", int'(locked), 1);
        runSteps(15);
        checkOutput("tmoDrop", int'(locked), 0);
        checkOutput("tmoErr", int'(err_count), 2);
        runSteps(5000 - 110);
        runToHc(0);
        hsHold = 0;
        runToHc(HS0);
        runSteps(2);
        checkOutput("tmoLineLen", int'(line_len), 2047);
        checkOutput("tmoErrHeld", int'(err_count), 2);
        gotLock = 0;
        for (int i = 0; i < 4000 && !gotLock; i++) begin
            applyStimulus();
            if (locked) gotLock = 1;
        end
        checkOutput("tmoRelock", int'(gotLock), 1);

        // Asynchronous reset in the middle of a visible line.
        runToPos(2, 10);
        checkOutput("preRstX", int'(x), 8);
        checkOutput("preRstY", int'(y), 2);
        checkOutput("preRstPixel", int'(pixel), 8);
        #2 reset = 1'b0;
        #1;
        checkOutput("midRstLocked", int'(locked), 0);
        checkOutput("midRstX", int'(x), 0);
        checkOutput("midRstY", int'(y), 0);
        checkOutput("midRstPixelValid", int'(pixel_valid), 0);
        checkOutput("midRstLineLen", int'(line_len), 0);
        checkOutput("midRstFrameLines", int'(frame_lines), 0);
        checkOutput("midRstErr", int'(err_count), 0);
        runSteps(2);
        reset = 1'b1;
        runToVfall();
        runSteps(2);
        checkOutput("rstFirstVfall", int'(locked), 0);
        runToVfall();
        runSteps(1);
        checkOutput("rstLockNotEarly", int'(locked), 0);
        runSteps(1);
        checkOutput("rstRelock", int'(locked), 1);
        checkOutput("rstRelockErr", int'(err_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/vga_timing_rx.md
Name: vga_timing_rx

Overview:
- Receive-side counterpart of the VGA timing generator: samples incoming hsync/vsync/blank/colour, measures line and frame timing, and locks when the timing matches the configured mode.
- Once locked, regenerates pixel x/y coordinates and a qualified pixel strobe for capture logic (frame grabber, loopback checker, scope capture).
- Sits at the input of any block that consumes a 640x480@60 video stream on the 25.2 MHz pixel clock.

Parameters:
- H_TOTAL, 800, expected clocks per line (hsync fall to hsync fall)
- V_TOTAL, 525, expected lines per frame (vsync fall to vsync fall)
- H_VISIBLE, 640, expected active pixels per line
- V_VISIBLE, 480, expected active lines per frame
- TIMEOUT, 4095, clocks without an hsync fall before declaring sync loss

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- hsync_in  in  1  horizontal sync, active-low pulse
- vsync_in  in  1  vertical sync, active-low pulse
- blank_in  in  1  high outside visible area
- color_in  in  6  RRGGBB pixel
- x  out  10  active-pixel column, 0..H_VISIBLE-1
- y  out  9  active-line row, 0..V_VISIBLE-1
- pixel  out  6  registered colour aligned with x/y
- pixel_valid  out  1  locked and in the visible area
- frame_start  out  1  one-cycle pulse on each vsync fall while locked
- locked  out  1  timing matches parameters
- line_len  out  11  last measured line length, saturating at 2047
- frame_lines  out  10  last measured line count, saturating at 1023
- err_count  out  8  lock-loss events, saturating at 255

Behaviour:
- Reset (async, active-low):
  - All outputs go to 0; FSM enters SEARCH.
  - Input sample registers are set to the idle values hsync = 1, vsync = 1, blank = 1.
- Input stage:
  - hsync_in, vsync_in, blank_in and color_in are registered once.
  - Edges are detected against a second register. An hsync fall (h_fall) is prev = 1, cur = 0; a vsync fall (v_fall) is defined the same way.
  - All outputs lag the inputs by 2 clocks.
- hcnt (11-bit):
  - Increments every clock and saturates at 2047.
  - On h_fall: line_len <= hcnt + 1 (saturating), then hcnt <= 0.
- vcnt (10-bit):
  - Increments on each h_fall and saturates at 1023.
  - On v_fall: frame_lines <= vcnt, then vcnt <= 0.
  - When h_fall and v_fall coincide, the h_fall increment is applied first, so vcnt <= 0.
- Timeout counter: cleared by h_fall, otherwise increments; reaching TIMEOUT counts as a mismatch.
- FSM:
  - SEARCH: wait for v_fall, then go to MEASURE and clear the bad flag.
  - MEASURE:
    - Any h_fall with a new line_len != H_TOTAL, or a timeout, sets bad.
    - At the next v_fall: if !bad and the new frame_lines == V_TOTAL, go to LOCKED; else stay in MEASURE and clear bad.
  - LOCKED: any of the following goes to SEARCH next cycle, with locked deasserted that same cycle and err_count incremented once:
    - h_fall with line_len != H_TOTAL
    - v_fall with frame_lines != V_TOTAL
    - timeout
- locked: 1 only in LOCKED; asserts the cycle after the qualifying v_fall.
- frame_start: pulses on each v_fall in LOCKED that does not drop lock. The locking v_fall itself does not pulse.
- x/y generation (active only while locked):
  - x = 0 on the first sampled cycle of a line with blank = 0.
  - x increments on each following blank = 0 cycle and saturates at H_VISIBLE-1.
  - x holds while blank = 1 and returns to 0 at the next h_fall.
  - y advances by 1 at the first h_fall after a line containing any blank = 0 cycle, saturating at V_VISIBLE-1.
  - y returns to 0 on v_fall.
- pixel_valid: locked & ~blank_sampled. pixel = color_sampled when pixel_valid, else 0.
- When not locked: x, y, pixel_valid and pixel are forced to 0, while line_len, frame_lines and err_count keep updating.

Test Plan:
- Drive the generator's 800x525 stream from reset:
  - locked rises 1 clock after the second v_fall.
  - line_len = 800, frame_lines = 525.
  - Following frame: 307200 pixel_valid cycles; x spans 0..639, y spans 0..479.
- While locked, stretch one line to 801 clocks:
  - locked drops the cycle after that h_fall and err_count = 1.
  - Relock occurs after one further clean full frame.
- Hold hsync_in high for 5000 clocks while locked:
  - locked drops at TIMEOUT.
  - line_len then reads 2047 on the next h_fall.
- Feed 800x526 timing:
  - locked never asserts; frame_lines = 526 each frame.
  - err_count stays 0.
- Assert reset mid-line while locked:
  - All outputs 0 immediately, asynchronously.
  - After release, relock takes the same two v_fall sequence as from power-up.
- While locked, check alignment of pixel with x/y:
  - Colour ramp color_in = hcounter[5:0] gives pixel == x[5:0] on every pixel_valid cycle.
  - frame_start pulses exactly once per frame.
